// File: rtl/z80_alu_ind_hl_seq_pkg.sv
// Shared constants and types for the ALU A,(HL) sequencer.
// Contents: ALU function codes, flag masks, the 10ooo110 opcode match
// constants, the latched instruction context and small decode helpers.
package z80_alu_ind_hl_seq_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned FUNC_W = 3;

  // ALU function codes follow the ooo field of the 10ooo110 opcodes.
  typedef enum logic [FUNC_W-1:0] {
    ALU_FUNC_ADD = 3'd0,
    ALU_FUNC_ADC = 3'd1,
    ALU_FUNC_SUB = 3'd2,
    ALU_FUNC_SBC = 3'd3,
    ALU_FUNC_AND = 3'd4,
    ALU_FUNC_XOR = 3'd5,
    ALU_FUNC_OR  = 3'd6,
    ALU_FUNC_CP  = 3'd7
  } alu_func_e;

  // Single-bit masks into the F register.
  typedef enum logic [DATA_W-1:0] {
    FLAG_C_BIT  = 8'h01,
    FLAG_N_BIT  = 8'h02,
    FLAG_PV_BIT = 8'h04,
    FLAG_F3_BIT = 8'h08,
    FLAG_H_BIT  = 8'h10,
    FLAG_F5_BIT = 8'h20,
    FLAG_Z_BIT  = 8'h40,
    FLAG_S_BIT  = 8'h80
  } flag_mask_e;

  // Undocumented bits 5 and 3 keep their previous value across these ops.
  localparam logic [DATA_W-1:0] FLAG_KEEP_MASK =
    DATA_W'(FLAG_F5_BIT) | DATA_W'(FLAG_F3_BIT);

  localparam logic [1:0] OPC_ALU_GRP    = 2'b10;
  localparam logic [2:0] OPC_SRC_IND_HL = 3'b110;

  // Architectural state captured at dispatch.
  typedef struct packed {
    alu_func_e           op;
    logic [DATA_W-1:0]   a;
    logic [DATA_W-1:0]   f;
    logic [ADDR_W-1:0]   ip;
  } insn_ctx_t;

  function automatic logic is_alu_ind_hl(input logic [DATA_W-1:0] opc);
    return (opc[7:6] == OPC_ALU_GRP) && (opc[2:0] == OPC_SRC_IND_HL);
  endfunction

  function automatic logic uses_carry(input alu_func_e fn);
    return (fn == ALU_FUNC_ADC) || (fn == ALU_FUNC_SBC);
  endfunction

  function automatic logic [DATA_W-1:0] merge_flags(input logic [DATA_W-1:0] alu_fl,
                                                    input logic [DATA_W-1:0] old_f);
    return (alu_fl & ~FLAG_KEEP_MASK) | (old_f & FLAG_KEEP_MASK);
  endfunction

endpackage

// File: rtl/z80_mem_rd_cycle.sv
// Z80-style three-state memory read (T1, T2 with wait sampling, T3).
// Ports:
//   clk, reset_n        clock, async active-low reset
//   rd_start_i          begin a read at rd_addr_i (T1 next cycle)
//   rd_addr_i           read address, latched with rd_start_i
//   mem_rdata_i         bus read data, captured in T3
//   mem_wait_n_i        active-low wait request, sampled in T2
//   mem_rd_o            registered read strobe, high in T1..T3
//   mem_addr_o          registered read address
//   rd_done_c           high during T3 (data captured at the end of it)
//   rd_timeout_c        high in the T2 cycle that exhausts the wait budget
//   rd_data_o           captured data byte
module z80_mem_rd_cycle
  import z80_alu_ind_hl_seq_pkg::*;
#(
  parameter int unsigned WAIT_LIMIT = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              rd_start_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_wait_n_i,
  output logic              mem_rd_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              rd_done_c,
  output logic              rd_timeout_c,
  output logic [DATA_W-1:0] rd_data_o
);

  localparam int unsigned CNT_W = (WAIT_LIMIT < 2) ? 1 : $clog2(WAIT_LIMIT + 1);

  typedef enum logic [1:0] {RD_IDLE, RD_T1, RD_T2, RD_T3} rd_state_e;

  rd_state_e         state_q, state_d;
  logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic              mem_rd_q, mem_rd_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              limit_hit;

  // Current wait cycle is the last one allowed; a zero limit never expires.
  always_comb begin
    limit_hit = 1'b0;
    if (WAIT_LIMIT != 0) begin
      limit_hit = (wait_cnt_q == CNT_W'(WAIT_LIMIT - 1));
    end
  end

  // Read-cycle next state and strobes.
  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    mem_addr_d   = mem_addr_q;
    data_d       = data_q;
    rd_done_c    = 1'b0;
    rd_timeout_c = 1'b0;
    case (state_q)
      RD_IDLE: begin
        if (rd_start_i) begin
          state_d    = RD_T1;
          mem_addr_d = rd_addr_i;
          wait_cnt_d = '0;
        end
      end
      RD_T1: state_d = RD_T2;
      RD_T2: begin
        if (!mem_wait_n_i) begin
          if (limit_hit) begin
            state_d      = RD_IDLE;
            rd_timeout_c = 1'b1;
          end else begin
            wait_cnt_d = wait_cnt_q + CNT_W'(1);
          end
        end else begin
          state_d = RD_T3;
        end
      end
      RD_T3: begin
        data_d    = mem_rdata_i;
        rd_done_c = 1'b1;
        state_d   = RD_IDLE;
      end
      default: state_d = RD_IDLE;
    endcase
    // Strobe follows the state being entered so it is registered yet aligned.
    mem_rd_d = (state_d != RD_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= RD_IDLE;
      wait_cnt_q <= '0;
      mem_rd_q   <= 1'b0;
      mem_addr_q <= '0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      mem_rd_q   <= mem_rd_d;
      mem_addr_q <= mem_addr_d;
      data_q     <= data_d;
    end
  end

  assign mem_rd_o   = mem_rd_q;
  assign mem_addr_o = mem_addr_q;
  assign rd_data_o  = data_q;

endmodule

// File: rtl/z80_alu_ind_hl_seq.sv
// Sequencer for the eight ALU A,(HL) opcodes: reads (HL), runs the shared
// ALU on A and the fetched byte, then writes A, F and IP back.
// Ports:
//   clk, reset_n                    clock, async active-low reset
//   start, insn, reg_*_in           dispatch pulse with opcode and operands
//   busy                            high from T1 through WB
//   mem_rd, mem_addr, mem_rdata,
//   mem_wait_n                      memory read bus
//   alu_func, alu_a, alu_b, alu_cin shared ALU request (driven in EXEC only)
//   alu_result, alu_flags           shared ALU response
//   a_we/f_we/ip_we, a_out/f_out/
//   ip_out                          register-file writeback
//   done, illegal, timeout          mutually exclusive one-cycle pulses
module z80_alu_ind_hl_seq
  import z80_alu_ind_hl_seq_pkg::*;
#(
  parameter int unsigned WAIT_LIMIT = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [DATA_W-1:0] insn,
  input  logic [DATA_W-1:0] reg_a_in,
  input  logic [DATA_W-1:0] reg_f_in,
  input  logic [ADDR_W-1:0] reg_hl_in,
  input  logic [ADDR_W-1:0] reg_ip_in,
  output logic              busy,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_wait_n,
  output logic [FUNC_W-1:0] alu_func,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic              alu_cin,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] alu_flags,
  output logic              a_we,
  output logic              f_we,
  output logic              ip_we,
  output logic [DATA_W-1:0] a_out,
  output logic [DATA_W-1:0] f_out,
  output logic [ADDR_W-1:0] ip_out,
  output logic              done,
  output logic              illegal,
  output logic              timeout
);

  // T1..T3 live in the read sub-module while this FSM sits in SEQ_READ.
  typedef enum logic [1:0] {SEQ_IDLE, SEQ_READ, SEQ_EXEC, SEQ_WB} seq_state_e;

  seq_state_e        state_q, state_d;
  insn_ctx_t         ctx_q, ctx_d;
  logic              busy_q, busy_d;
  logic              a_we_q, a_we_d;
  logic              f_we_q, f_we_d;
  logic              ip_we_q, ip_we_d;
  logic              done_q, done_d;
  logic              illegal_q, illegal_d;
  logic              timeout_q, timeout_d;
  logic [DATA_W-1:0] a_out_q, a_out_d;
  logic [DATA_W-1:0] f_out_q, f_out_d;
  logic [ADDR_W-1:0] ip_out_q, ip_out_d;

  logic              dispatch_c;
  logic              rd_done_c;
  logic              rd_timeout_c;
  logic [DATA_W-1:0] rd_data;

  assign dispatch_c = (state_q == SEQ_IDLE) && start && is_alu_ind_hl(insn);

  z80_mem_rd_cycle #(
    .WAIT_LIMIT (WAIT_LIMIT)
  ) u_mem_rd (
    .clk          (clk),
    .reset_n      (reset_n),
    .rd_start_i   (dispatch_c),
    .rd_addr_i    (reg_hl_in),
    .mem_rdata_i  (mem_rdata),
    .mem_wait_n_i (mem_wait_n),
    .mem_rd_o     (mem_rd),
    .mem_addr_o   (mem_addr),
    .rd_done_c    (rd_done_c),
    .rd_timeout_c (rd_timeout_c),
    .rd_data_o    (rd_data)
  );

  // Sequencer next state; writeback values are registered on EXEC -> WB.
  always_comb begin
    state_d   = state_q;
    ctx_d     = ctx_q;
    a_we_d    = 1'b0;
    f_we_d    = 1'b0;
    ip_we_d   = 1'b0;
    done_d    = 1'b0;
    illegal_d = 1'b0;
    timeout_d = 1'b0;
    a_out_d   = a_out_q;
    f_out_d   = f_out_q;
    ip_out_d  = ip_out_q;
    case (state_q)
      SEQ_IDLE: begin
        if (start) begin
          if (is_alu_ind_hl(insn)) begin
            ctx_d.op = alu_func_e'(insn[5:3]);
            ctx_d.a  = reg_a_in;
            ctx_d.f  = reg_f_in;
            ctx_d.ip = reg_ip_in;
            state_d  = SEQ_READ;
          end else begin
            illegal_d = 1'b1;
          end
        end
      end
      SEQ_READ: begin
        if (rd_timeout_c) begin
          state_d   = SEQ_IDLE;
          timeout_d = 1'b1;
        end else if (rd_done_c) begin
          state_d = SEQ_EXEC;
        end
      end
      SEQ_EXEC: begin
        state_d  = SEQ_WB;
        a_out_d  = alu_result;
        a_we_d   = (ctx_q.op != ALU_FUNC_CP);
        f_out_d  = merge_flags(alu_flags, ctx_q.f);
        f_we_d   = 1'b1;
        ip_out_d = ctx_q.ip + ADDR_W'(1);
        ip_we_d  = 1'b1;
        done_d   = 1'b1;
      end
      SEQ_WB:  state_d = SEQ_IDLE;
      default: state_d = SEQ_IDLE;
    endcase
    busy_d = (state_d != SEQ_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= SEQ_IDLE;
      ctx_q     <= '0;
      busy_q    <= 1'b0;
      a_we_q    <= 1'b0;
      f_we_q    <= 1'b0;
      ip_we_q   <= 1'b0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
      a_out_q   <= '0;
      f_out_q   <= '0;
      ip_out_q  <= '0;
    end else begin
      state_q   <= state_d;
      ctx_q     <= ctx_d;
      busy_q    <= busy_d;
      a_we_q    <= a_we_d;
      f_we_q    <= f_we_d;
      ip_we_q   <= ip_we_d;
      done_q    <= done_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
      a_out_q   <= a_out_d;
      f_out_q   <= f_out_d;
      ip_out_q  <= ip_out_d;
    end
  end

  // ALU request is a pure decode of registered state, zero outside EXEC.
  always_comb begin
    alu_func = '0;
    alu_a    = '0;
    alu_b    = '0;
    alu_cin  = 1'b0;
    if (state_q == SEQ_EXEC) begin
      alu_func = ctx_q.op;
      alu_a    = ctx_q.a;
      alu_b    = rd_data;
      alu_cin  = uses_carry(ctx_q.op) && ((ctx_q.f & DATA_W'(FLAG_C_BIT)) != '0);
    end
  end

  assign busy    = busy_q;
  assign a_we    = a_we_q;
  assign f_we    = f_we_q;
  assign ip_we   = ip_we_q;
  assign a_out   = a_out_q;
  assign f_out   = f_out_q;
  assign ip_out  = ip_out_q;
  assign done    = done_q;
  assign illegal = illegal_q;
  assign timeout = timeout_q;

endmodule
